agrupador_garrafas: RTL and testbench

Upstream source of dozen-count pulses for the end-of-line counter. Watches the raw final-position bottle sensor, synchronizes and debounces it, and counts confirmed bottles. Emits a single-cycle `duzia_pulso` on every twelfth bottle, intended to drive the dozen counter's increment input directly. Also flags a sensor held active too long (jammed bottle or failed sensor).

---
 rtl/agrupador_garrafas_pkg.sv | 17 +
 rtl/agrupador_garrafas_if.sv | 23 ++
 rtl/agrupador_garrafas_sincronizador_2ff.sv | 24 ++
 rtl/agrupador_garrafas.sv | 177 +++++++++++++++++
 tb/tb_agrupador_garrafas.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/agrupador_garrafas_pkg.sv
// Shared definitions for the bottle grouper: FSM state encoding and the
// default timing constants for a 50 MHz line clock.
package agrupador_garrafas_pkg;

    typedef logic [2:0] estado_t;

    localparam estado_t ST_OCIOSO           = 3'd0;
    localparam estado_t ST_CONFIRMA_ENTRADA = 3'd1;
    localparam estado_t ST_PRESENTE         = 3'd2;
    localparam estado_t ST_CONFIRMA_SAIDA   = 3'd3;
    localparam estado_t ST_TRAVADO          = 3'd4;

    localparam int GARRAFAS_POR_DUZIA_DEF = 12;
    localparam int DEBOUNCE_CICLOS_DEF    = 500000;
    localparam int MAX_PRESENCA_DEF       = 50000000;

endpackage

// File: rtl/agrupador_garrafas_if.sv
// Sensor/control inputs and count/alarm outputs of the bottle grouper.
// The master side drives the sensor and line controls; the slave is the grouper.
interface agrupador_garrafas_if;

    logic       sensor_final;
    logic       habilitar;
    logic       limpar;
    logic       garrafa_pulso;
    logic       duzia_pulso;
    logic [3:0] garrafas_valor;
    logic       sensor_preso;

    modport master (
        output sensor_final, habilitar, limpar,
        input  garrafa_pulso, duzia_pulso, garrafas_valor, sensor_preso
    );

    modport slave (
        input  sensor_final, habilitar, limpar,
        output garrafa_pulso, duzia_pulso, garrafas_valor, sensor_preso
    );

endinterface

// File: rtl/agrupador_garrafas_sincronizador_2ff.sv
// Two-flop synchronizer for raw asynchronous line sensors.
module sincronizador_2ff (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/agrupador_garrafas.sv
// Debounces the final-position bottle sensor, counts bottles and pulses once per dozen.
// Define AGRUPADOR_DEBOUNCE_EN to build the entry/exit confirmation states.
module agrupador_garrafas
    import agrupador_garrafas_pkg::*;
#(
    parameter int GARRAFAS_POR_DUZIA = GARRAFAS_POR_DUZIA_DEF,
    parameter int DEBOUNCE_CICLOS    = DEBOUNCE_CICLOS_DEF,
    parameter int MAX_PRESENCA       = MAX_PRESENCA_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    agrupador_garrafas_if.slave  bus
);

    localparam int W_PRES = (MAX_PRESENCA > 1) ? $clog2(MAX_PRESENCA) : 1;
    localparam logic [W_PRES-1:0] C_PRES_FIM  = W_PRES'(MAX_PRESENCA - 1);
    localparam logic [3:0]        C_VALOR_FIM = 4'(GARRAFAS_POR_DUZIA - 1);

    if (GARRAFAS_POR_DUZIA < 2 || GARRAFAS_POR_DUZIA > 15) begin : g_erro_duzia
        $error("GARRAFAS_POR_DUZIA must lie in 2..15");
    end
    if (DEBOUNCE_CICLOS < 2) begin : g_erro_debounce
        $error("DEBOUNCE_CICLOS must be at least 2");
    end

    logic              w_sensor_s;
    logic              w_evento;
    estado_t           r_estado;
    logic [W_PRES-1:0] r_presenca;
    logic              r_sensor_preso;
    logic              r_garrafa_pulso;
    logic              r_duzia_pulso;
    logic [3:0]        r_valor;

    sincronizador_2ff u_sinc (
        .clk   (clk),
        .reset (reset),
        .i_d   (bus.sensor_final),
        .o_q   (w_sensor_s)
    );

`ifdef AGRUPADOR_DEBOUNCE_EN
    localparam int W_EST = $clog2(DEBOUNCE_CICLOS);
    localparam logic [W_EST-1:0] C_EST_FIM = W_EST'(DEBOUNCE_CICLOS - 1);

    logic [W_EST-1:0] r_estab;

    // Detection fires on the edge that completes the entry confirmation.
    assign w_evento = (r_estado == ST_CONFIRMA_ENTRADA) && w_sensor_s && (r_estab == C_EST_FIM);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado       <= ST_OCIOSO;
            r_estab        <= '0;
            r_presenca     <= '0;
            r_sensor_preso <= 1'b0;
        end else begin
            case (r_estado)
                ST_OCIOSO: begin
                    if (w_sensor_s) begin
                        r_estado <= ST_CONFIRMA_ENTRADA;
                        r_estab  <= '0;
                    end
                end
                ST_CONFIRMA_ENTRADA: begin
                    if (!w_sensor_s) begin
                        r_estado <= ST_OCIOSO;
                    end else if (r_estab == C_EST_FIM) begin
                        r_estado   <= ST_PRESENTE;
                        r_presenca <= '0;
                    end else begin
                        r_estab <= r_estab + 1'b1;
                    end
                end
                ST_PRESENTE: begin
                    if (!w_sensor_s) begin
                        r_estado <= ST_CONFIRMA_SAIDA;
                        r_estab  <= '0;
                    end else if (r_presenca == C_PRES_FIM) begin
                        r_estado       <= ST_TRAVADO;
                        r_estab        <= '0;
                        r_sensor_preso <= 1'b1;
                    end else begin
                        r_presenca <= r_presenca + 1'b1;
                    end
                end
                // A bounce back high resumes presence timing where it left off.
                ST_CONFIRMA_SAIDA: begin
                    if (w_sensor_s) begin
                        r_estado <= ST_PRESENTE;
                    end else if (r_estab == C_EST_FIM) begin
                        r_estado <= ST_OCIOSO;
                    end else begin
                        r_estab <= r_estab + 1'b1;
                    end
                end
                ST_TRAVADO: begin
                    if (w_sensor_s) begin
                        r_estab <= '0;
                    end else if (r_estab == C_EST_FIM) begin
                        r_estado       <= ST_OCIOSO;
                        r_sensor_preso <= 1'b0;
                    end else begin
                        r_estab <= r_estab + 1'b1;
                    end
                end
                default: r_estado <= ST_OCIOSO;
            endcase
        end
    end
`else
    assign w_evento = (r_estado == ST_OCIOSO) && w_sensor_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado       <= ST_OCIOSO;
            r_presenca     <= '0;
            r_sensor_preso <= 1'b0;
        end else begin
            case (r_estado)
                ST_OCIOSO: begin
                    if (w_sensor_s) begin
                        r_estado   <= ST_PRESENTE;
                        r_presenca <= '0;
                    end
                end
                ST_PRESENTE: begin
                    if (!w_sensor_s) begin
                        r_estado <= ST_OCIOSO;
                    end else if (r_presenca == C_PRES_FIM) begin
                        r_estado       <= ST_TRAVADO;
                        r_sensor_preso <= 1'b1;
                    end else begin
                        r_presenca <= r_presenca + 1'b1;
                    end
                end
                ST_TRAVADO: begin
                    if (!w_sensor_s) begin
                        r_estado       <= ST_OCIOSO;
                        r_sensor_preso <= 1'b0;
                    end
                end
                default: r_estado <= ST_OCIOSO;
            endcase
        end
    end
`endif

    // Clear wins over a same-cycle detection, so that bottle is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valor         <= '0;
            r_garrafa_pulso <= 1'b0;
            r_duzia_pulso   <= 1'b0;
        end else begin
            r_garrafa_pulso <= 1'b0;
            r_duzia_pulso   <= 1'b0;
            if (bus.limpar) begin
                r_valor <= '0;
            end else if (w_evento && bus.habilitar) begin
                r_garrafa_pulso <= 1'b1;
                if (r_valor == C_VALOR_FIM) begin
                    r_valor       <= '0;
                    r_duzia_pulso <= 1'b1;
                end else begin
                    r_valor <= r_valor + 1'b1;
                end
            end
        end
    end

    assign bus.garrafa_pulso  = r_garrafa_pulso;
    assign bus.duzia_pulso    = r_duzia_pulso;
    assign bus.garrafas_valor = r_valor;
    assign bus.sensor_preso   = r_sensor_preso;

endmodule

// File: tb/tb_agrupador_garrafas.sv
// Directed bench for agrupador_garrafas with DEBOUNCE_CICLOS=4, MAX_PRESENCA=20.
// Expected timing follows AGRUPADOR_DEBOUNCE_EN, so both builds share this bench.
module tb_agrupador_garrafas;

    localparam int N_DUZIA = 12;
    localparam int DEB     = 4;
    localparam int MAXP    = 20;
`ifdef AGRUPADOR_DEBOUNCE_EN
    localparam int LAT     = 3 + DEB;
    localparam int D_SAIDA = DEB;
    localparam int G_GLITCH = 0;
`else
    localparam int LAT     = 3;
    localparam int D_SAIDA = 1;
    localparam int G_GLITCH = 1;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   nG;
    int   nD;
    int   firstG;
    int   nDsemG;
    int   valorEsp;

    agrupador_garrafas_if io ();

    agrupador_garrafas #(
        .GARRAFAS_POR_DUZIA (N_DUZIA),
        .DEBOUNCE_CICLOS    (DEB),
        .MAX_PRESENCA       (MAXP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then tally any pulses seen.
    task automatic tick(input int k);
        @(negedge clk);
        if (io.garrafa_pulso) begin
            nG++;
            if (firstG < 0) firstG = k;
        end
        if (io.duzia_pulso) begin
            nD++;
            if (!io.garrafa_pulso) nDsemG++;
        end
    endtask

    task automatic clearStats();
        nG = 0;
        nD = 0;
        firstG = -1;
        nDsemG = 0;
    endtask

    task automatic applyStimulus(input logic nivel, input int ciclos);
        io.sensor_final = nivel;
        for (int k = 1; k <= ciclos; k++) tick(k);
    endtask

    task automatic bottle();
        clearStats();
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 10);
    endtask

    task automatic clearCount();
        io.limpar = 1'b1;
        tick(0);
        io.limpar = 1'b0;
        checkOutput("limpar_valor", int'(io.garrafas_valor), 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valor"}, int'(io.garrafas_valor), 0);
        checkOutput({tag, "_garrafa"}, int'(io.garrafa_pulso), 0);
        checkOutput({tag, "_duzia"}, int'(io.duzia_pulso), 0);
        checkOutput({tag, "_preso"}, int'(io.sensor_preso), 0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        clearStats();
        reset = 1'b1;
        io.sensor_final = 1'b0;
        io.habilitar = 1'b1;
        io.limpar = 1'b0;
        for (int k = 0; k < 3; k++) tick(0);
        checkAllZero("em_reset");
        reset = 1'b0;
        tick(0);
        checkAllZero("pos_reset");

        $display("[TB] twelve clean bottles");
        for (int i = 0; i < N_DUZIA; i++) begin
            bottle();
            checkOutput("dozen_garrafa_n", nG, 1);
            checkOutput("dozen_latencia", firstG, LAT);
            checkOutput("dozen_valor", int'(io.garrafas_valor), (i + 1) % N_DUZIA);
            checkOutput("dozen_duzia_n", nD, (i == N_DUZIA - 1) ? 1 : 0);
            checkOutput("dozen_coincide", nDsemG, 0);
        end

        $display("[TB] two-cycle glitch");
        clearStats();
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 10);
        checkOutput("glitch_garrafa_n", nG, G_GLITCH);
        checkOutput("glitch_valor", int'(io.garrafas_valor), G_GLITCH);
        valorEsp = G_GLITCH;

        $display("[TB] jammed sensor");
        clearStats();
        io.sensor_final = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick(k);
            if (k == LAT + MAXP - 1) checkOutput("jam_preso_antes", int'(io.sensor_preso), 0);
            if (k == LAT + MAXP)     checkOutput("jam_preso_set", int'(io.sensor_preso), 1);
        end
        checkOutput("jam_garrafa_n", nG, 1);
        checkOutput("jam_latencia", firstG, LAT);
        io.sensor_final = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick(k);
            if (k == D_SAIDA + 1) checkOutput("jam_preso_mantem", int'(io.sensor_preso), 1);
            if (k == D_SAIDA + 2) checkOutput("jam_preso_limpo", int'(io.sensor_preso), 0);
        end
        checkOutput("jam_sem_extra", nG, 1);
        valorEsp++;
        checkOutput("jam_valor", int'(io.garrafas_valor), valorEsp);

        $display("[TB] clear coincident with detection");
        clearCount();
        for (int i = 0; i < 5; i++) bottle();
        checkOutput("limpar_pre_valor", int'(io.garrafas_valor), 5);
        clearStats();
        io.sensor_final = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            io.limpar = (k == LAT);
            tick(k);
            if (k == LAT) checkOutput("limpar_coinc_valor", int'(io.garrafas_valor), 0);
        end
        io.limpar = 1'b0;
        applyStimulus(1'b0, 10);
        checkOutput("limpar_garrafa_n", nG, 0);
        checkOutput("limpar_duzia_n", nD, 0);
        bottle();
        checkOutput("limpar_prox_valor", int'(io.garrafas_valor), 1);

        $display("[TB] line disabled");
        clearCount();
        io.habilitar = 1'b0;
        clearStats();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 10);
            applyStimulus(1'b0, 10);
        end
        checkOutput("hab0_garrafa_n", nG, 0);
        checkOutput("hab0_valor", int'(io.garrafas_valor), 0);
        clearStats();
        io.sensor_final = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k == LAT + 3) io.habilitar = 1'b1;
            tick(k);
        end
        applyStimulus(1'b0, 10);
        checkOutput("hab_meio_garrafa_n", nG, 0);
        checkOutput("hab_meio_valor", int'(io.garrafas_valor), 0);
        bottle();
        checkOutput("hab_prox_garrafa_n", nG, 1);
        checkOutput("hab_prox_valor", int'(io.garrafas_valor), 1);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 6; i++) bottle();
        checkOutput("reset_pre_valor", int'(io.garrafas_valor), 7);
        io.sensor_final = 1'b1;
        tick(1);
        tick(2);
        reset = 1'b1;
        tick(3);
        checkAllZero("reset_meio");
        reset = 1'b0;
        clearStats();
        for (int k = 1; k <= 10; k++) tick(k);
        applyStimulus(1'b0, 10);
        checkOutput("reset_alto_garrafa_n", nG, 1);
        checkOutput("reset_alto_latencia", firstG, LAT);
        checkOutput("reset_alto_valor", int'(io.garrafas_valor), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
